// File: rtl/digest_reader.sv
// Streams a LEN-byte digest out of the shared single-port byte RAM as a
// valid/ready byte stream split into CHUNK-byte groups, one read at a time.
module digest_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN    = 32,
  parameter int CHUNK  = 8,
  parameter int RD_LAT = 1,
  localparam int CW    = $clog2((LEN + CHUNK - 1) / CHUNK) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [CW-1:0]     out_chunk
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int RW = $clog2(RD_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
  localparam logic [PW-1:0] LAST_POS = PW'(CHUNK - 1);
  localparam logic [RW-1:0] LAST_RD  = RW'(RD_LAT);

  typedef enum logic [2:0] {IDLE, REQ, RD, OUT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [IW-1:0]     idx;
  logic [PW-1:0]     pos;
  logic [CW-1:0]     chunk_cnt;
  logic [RW-1:0]     rd_cnt;

  // pos and chunk_cnt track idx mod CHUNK and idx / CHUNK without dividers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      pos       <= '0;
      chunk_cnt <= '0;
      rd_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_chunk <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base      <= base_addr;
            idx       <= '0;
            pos       <= '0;
            chunk_cnt <= '0;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            rd_cnt   <= '0;
            mem_cs   <= 1'b1;
            mem_oe   <= 1'b1;
            mem_addr <= base + ADDR_W'(idx);
            state    <= RD;
          end
        end
        RD: begin
          // losing the bus abandons this read; the same idx is retried on regrant
          if (!mem_gnt) begin
            mem_cs <= 1'b0;
            mem_oe <= 1'b0;
            state  <= REQ;
          end else if (rd_cnt == LAST_RD) begin
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            out_first <= (pos == '0);
            out_last  <= (pos == LAST_POS) || (idx == LAST_IDX);
            out_chunk <= chunk_cnt;
            state     <= OUT;
          end else begin
            rd_cnt <= rd_cnt + RW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_chunk <= '0;
            if (idx == LAST_IDX) begin
              done    <= 1'b1;
              mem_req <= 1'b0;
              state   <= DONE;
            end else begin
              idx <= idx + IW'(1);
              if (pos == LAST_POS) begin
                pos       <= '0;
                chunk_cnt <= chunk_cnt + CW'(1);
              end else begin
                pos <= pos + PW'(1);
              end
              state <= REQ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// Bench for digest_reader: two instances (LEN 32 and LEN 10) against a
// transaction-level model of the expected byte stream and bus behaviour.
module tb_digest_reader;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CH = 8;
  localparam int LENS [2] = '{32, 10};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start [2];
  logic [AW-1:0] base  [2];
  logic          gnt   [2];
  logic          ready [2];
  logic          busy  [2];
  logic          done  [2];
  logic          req   [2];
  logic [AW-1:0] addr  [2];
  logic          cs    [2];
  logic          oe    [2];
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] data  [2];
  logic          valid [2];
  logic          first [2];
  logic          last  [2];
  logic [3:0]    chunk [2];
  logic [2:0]    chunk0;
  logic [1:0]    chunk1;
  assign chunk[0] = {1'b0, chunk0};
  assign chunk[1] = {2'b00, chunk1};

  digest_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN(32), .CHUNK(CH), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base[0]), .busy(busy[0]),
    .done(done[0]), .mem_req(req[0]), .mem_gnt(gnt[0]), .mem_addr(addr[0]),
    .mem_cs(cs[0]), .mem_oe(oe[0]), .mem_rdata(rdata[0]), .out_data(data[0]),
    .out_valid(valid[0]), .out_ready(ready[0]), .out_first(first[0]),
    .out_last(last[0]), .out_chunk(chunk0));

  digest_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN(10), .CHUNK(CH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base[1]), .busy(busy[1]),
    .done(done[1]), .mem_req(req[1]), .mem_gnt(gnt[1]), .mem_addr(addr[1]),
    .mem_cs(cs[1]), .mem_oe(oe[1]), .mem_rdata(rdata[1]), .out_data(data[1]),
    .out_valid(valid[1]), .out_ready(ready[1]), .out_first(first[1]),
    .out_last(last[1]), .out_chunk(chunk1));

  // RAM with one cycle read latency; mem[a] = a + 0x60, so 64..95 hold A0..BF
  logic [7:0] mem [1024];
  initial for (int a = 0; a < 1024; a++) mem[a] = 8'(a + 'h60);
  always @(posedge clk) for (int i = 0; i < 2; i++) rdata[i] <= mem[addr[i]];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // model state
  bit            mb [2];
  bit            pend [2];
  int            k [2];
  logic [AW-1:0] mbase [2];
  int            cyc = 0;
  int            c0 [2];
  int            span [2];
  int            fspan [2];
  int            ndone [2] = '{0, 0};
  logic [7:0]    hs [2][32];
  logic [31:0]   lastmask [2];
  logic          pv [2], pr [2], pg [2], pfirst [2], plast [2];
  logic [7:0]    pdata [2];
  logic [3:0]    pchunk [2];
  logic          acc;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mb[i] = 0; pend[i] = 0; k[i] = 0; pv[i] = 0;
      end else begin
        chk($sformatf("u%0d busy", i), 32'(busy[i]), 32'(mb[i]));
        chk($sformatf("u%0d done", i), 32'(done[i]), 32'(pend[i]));
        chk($sformatf("u%0d mem_req", i), 32'(req[i]), 32'(mb[i] && !pend[i]));
        chk($sformatf("u%0d oe==cs", i), 32'(oe[i]), 32'(cs[i]));
        if (!mb[i] || pend[i])
          chk($sformatf("u%0d valid outside transfer", i), 32'(valid[i]), 32'd0);
        if (cs[i]) begin
          chk($sformatf("u%0d cs without grant", i), 32'(pg[i]), 32'd1);
          chk($sformatf("u%0d cs during valid", i), 32'(valid[i]), 32'd0);
          chk($sformatf("u%0d addr", i), 32'(addr[i]), 32'(10'(mbase[i] + 10'(k[i]))));
        end
        if (pv[i] && !pr[i]) begin
          chk($sformatf("u%0d hold valid", i), 32'(valid[i]), 32'd1);
          chk($sformatf("u%0d hold data", i), 32'(data[i]), 32'(pdata[i]));
          chk($sformatf("u%0d hold flags", i), 32'({first[i], last[i], chunk[i]}),
              32'({pfirst[i], plast[i], pchunk[i]}));
        end
        acc = start[i] && !mb[i];
        if (pend[i]) begin
          ndone[i]++; mb[i] = 0; pend[i] = 0;
        end
        if (valid[i] && ready[i] && mb[i] && k[i] < LENS[i]) begin
          chk($sformatf("u%0d data[%0d]", i, k[i]), 32'(data[i]), 32'(mem[10'(mbase[i] + 10'(k[i]))]));
          chk($sformatf("u%0d first[%0d]", i, k[i]), 32'(first[i]), 32'(k[i] % CH == 0));
          chk($sformatf("u%0d last[%0d]", i, k[i]), 32'(last[i]),
              32'((k[i] % CH == CH - 1) || (k[i] == LENS[i] - 1)));
          chk($sformatf("u%0d chunk[%0d]", i, k[i]), 32'(chunk[i]), 32'(k[i] / CH));
          hs[i][k[i]] = data[i];
          if (last[i]) lastmask[i][k[i]] = 1'b1;
          if (k[i] == 0) fspan[i] = cyc - c0[i];
          if (k[i] == LENS[i] - 1) begin
            pend[i] = 1; span[i] = cyc - c0[i];
          end
          k[i]++;
        end
        if (acc) begin
          mb[i] = 1; mbase[i] = base[i]; k[i] = 0; c0[i] = cyc; lastmask[i] = '0;
        end
      end
      pv[i] = valid[i]; pr[i] = ready[i]; pg[i] = gnt[i];
      pdata[i] = data[i]; pfirst[i] = first[i]; plast[i] = last[i]; pchunk[i] = chunk[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int i, input logic [AW-1:0] b);
    start[i] = 1'b1; base[i] = b;
    tick(1);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string nm);
    int n0 = ndone[i];
    int t = 0;
    while (ndone[i] == n0 && t < 800) begin tick(1); t++; end
    chk({nm, " completion"}, 32'(ndone[i] != n0), 32'd1);
  endtask

  // wait until byte kk is in OUT (use_cs=0) or in its first RD cycle (use_cs=1)
  task automatic wait_for(input int i, input int kk, input bit use_cs);
    int t = 0;
    while (!((use_cs ? cs[i] : valid[i]) && k[i] == kk) && t < 400) begin tick(1); t++; end
    chk($sformatf("u%0d reach byte %0d", i, kk), 32'(t < 400), 32'd1);
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s u%0d outputs", nm, i),
          32'({busy[i], done[i], req[i], cs[i], oe[i], valid[i], first[i], last[i],
               chunk[i], addr[i], data[i]}), 32'd0);
  endtask

  int nd;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; base[i] = '0; gnt[i] = 1'b1; ready[i] = 1'b1;
    end
    tick(2);
    check_zero("reset");
    rst = 1'b1;
    tick(1);

    // basic read of 32 bytes from 64
    run(0, 10'd64);
    wait_done(0, "basic");
    chk("basic first byte", 32'(hs[0][0]), 32'h0A0);
    chk("basic last byte", 32'(hs[0][31]), 32'h0BF);
    chk("basic last flags", lastmask[0], 32'h8080_8080);
    chk("basic first latency", 32'(fspan[0]), 32'd4);
    chk("basic span", 32'(span[0]), 32'd128);

    // backpressure on byte 3
    run(0, 10'd64);
    wait_for(0, 3, 1'b0);
    ready[0] = 1'b0;
    tick(2);
    chk("stall byte", 32'({valid[0], data[0]}), 32'h1A3);
    tick(3);
    ready[0] = 1'b1;
    wait_done(0, "backpressure");
    chk("backpressure span", 32'(span[0]), 32'd133);

    // grant loss in the second RD cycle of byte 10
    run(0, 10'd64);
    wait_for(0, 10, 1'b1);
    tick(1);
    gnt[0] = 1'b0;
    tick(2);
    chk("cs while ungranted", 32'({cs[0], oe[0]}), 32'd0);
    tick(2);
    gnt[0] = 1'b1;
    wait_done(0, "grant loss");
    chk("grant loss byte 10", 32'(hs[0][10]), 32'h0AA);
    chk("grant loss byte 11", 32'(hs[0][11]), 32'h0AB);
    chk("grant loss span", 32'(span[0]), 32'd134);

    // wrap and short final chunk
    run(1, 10'd1020);
    wait_done(1, "wrap");
    chk("wrap byte 0", 32'(hs[1][0]), 32'h05C);
    chk("wrap byte 4", 32'(hs[1][4]), 32'h060);
    chk("wrap byte 9", 32'(hs[1][9]), 32'h065);
    chk("wrap last flags", lastmask[1], 32'h0000_0280);
    chk("wrap span", 32'(span[1]), 32'd40);

    // start while busy is ignored, then reset in OUT at byte 5
    run(0, 10'd64);
    wait_for(0, 2, 1'b0);
    run(0, 10'd512);
    wait_for(0, 5, 1'b0);
    nd = ndone[0];
    rst = 1'b0;
    tick(1);
    check_zero("abort");
    tick(1);
    rst = 1'b1;
    tick(3);
    chk("no done on abort", 32'(ndone[0]), 32'(nd));
    chk("idle after abort", 32'({busy[0], req[0], done[0]}), 32'd0);
    run(0, 10'd64);
    wait_done(0, "restart");
    chk("restart first byte", 32'(hs[0][0]), 32'h0A0);
    chk("restart span", 32'(span[0]), 32'd128);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
